pipe_stage_buf: RTL and testbench

- Parametrised, general-purpose pipeline stage register; the successor to the fixed-field, stall-vector stage latches between EX/MEM and the other stages.
- Replaces the global stall-vector scheme with a local valid/ready handshake. An optional skid entry lets upstream keep issuing for one cycle after downstream deasserts ready.
- Adds a synchronous flush for mispredict/exception squash, plus an occupancy output and a saturating backpressure-cycle counter for performance monitoring.
- Instantiated between any two pipeline stages; the payload is the packed stage bundle (wd, wreg, wdata, opcode, op, mem_addr, ...).

---
 rtl/pipe_stage_buf_if.sv | 26 ++
 rtl/pipe_stage_buf.sv | 108 ++++++++++
 tb/tb_pipe_stage_buf.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for one pipe_stage_buf: upstream/downstream valid-ready pairs,
// the flush input and the performance outputs.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 108,
  parameter int CNT_W  = 16
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occ_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, occ_o, stall_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, occ_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush, occupancy output and saturating backpressure counter.
module pipe_stage_buf #(
  parameter int DATA_W = 108,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_buf_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_v_reg, m_v_next;
  logic              s_v_reg, s_v_next;
  logic [DATA_W-1:0] m_d_reg, m_d_next;
  logic [DATA_W-1:0] s_d_reg, s_d_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic              in_ready;
  logic              accept;
  logic              drain;

  // With the skid entry, ready depends only on a flop; without it, ready
  // looks through to downstream so a full stage can be replaced on the same edge.
  assign in_ready = SKID ? !s_v_reg : (!m_v_reg || bus.out_ready_i);
  assign accept   = bus.in_valid_i && in_ready;
  assign drain    = m_v_reg && bus.out_ready_i;

  always_comb begin
    m_v_next = m_v_reg;
    s_v_next = s_v_reg;
    m_d_next = m_d_reg;
    s_d_next = s_d_reg;
    case ({m_v_reg, s_v_reg})
      ST_EMPTY: begin
        if (accept) begin
          m_v_next = 1'b1;
          m_d_next = bus.in_data_i;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          m_d_next = bus.in_data_i;
        end else if (accept && SKID) begin
          s_v_next = 1'b1;
          s_d_next = bus.in_data_i;
        end else if (drain) begin
          m_v_next = 1'b0;
          m_d_next = '0;
        end
      end
      ST_FULL: begin
        if (drain) begin
          m_d_next = s_d_reg;
          s_v_next = 1'b0;
          s_d_next = '0;
        end
      end
      default: begin
        m_v_next = 1'b0;
        s_v_next = 1'b0;
        m_d_next = '0;
        s_d_next = '0;
      end
    endcase
    // Squash wins over any same-edge accept; a same-edge drain already happened.
    if (bus.flush_i) begin
      m_v_next = 1'b0;
      s_v_next = 1'b0;
      m_d_next = '0;
      s_d_next = '0;
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (m_v_reg && !bus.out_ready_i && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v_reg       <= 1'b0;
      s_v_reg       <= 1'b0;
      m_d_reg       <= '0;
      s_d_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      m_v_reg       <= m_v_next;
      s_v_reg       <= s_v_next;
      m_d_reg       <= m_d_next;
      s_d_reg       <= s_d_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = m_v_reg;
  assign bus.out_data_o  = m_d_reg;
  assign bus.occ_o       = {1'b0, m_v_reg} + {1'b0, s_v_reg};
  assign bus.stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Drives three pipe_stage_buf variants (skid, no-skid, 4-bit counter) and checks
// every output each cycle against a queue-style FIFO model.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_buf_if #(.DATA_W(8), .CNT_W(16)) if0 ();
  pipe_stage_buf_if #(.DATA_W(8), .CNT_W(16)) if1 ();
  pipe_stage_buf_if #(.DATA_W(8), .CNT_W(4))  if2 ();

  pipe_stage_buf #(.DATA_W(8), .SKID(1'b1), .CNT_W(16)) u_skid   (.clk(clk), .rst(rst), .bus(if0.slave));
  pipe_stage_buf #(.DATA_W(8), .SKID(1'b0), .CNT_W(16)) u_noskid (.clk(clk), .rst(rst), .bus(if1.slave));
  pipe_stage_buf #(.DATA_W(8), .SKID(1'b1), .CNT_W(4))  u_sat    (.clk(clk), .rst(rst), .bus(if2.slave));

  logic       iv [3];
  logic       ir [3];
  logic       fl [3];
  logic [7:0] id [3];
  logic       ov [3];
  logic       ordy [3];
  logic [7:0] od [3];
  logic [1:0] oocc [3];
  logic [15:0] ocnt [3];

  assign if0.in_valid_i = iv[0]; assign if0.out_ready_i = ir[0]; assign if0.flush_i = fl[0]; assign if0.in_data_i = id[0];
  assign if1.in_valid_i = iv[1]; assign if1.out_ready_i = ir[1]; assign if1.flush_i = fl[1]; assign if1.in_data_i = id[1];
  assign if2.in_valid_i = iv[2]; assign if2.out_ready_i = ir[2]; assign if2.flush_i = fl[2]; assign if2.in_data_i = id[2];
  assign ov[0] = if0.out_valid_o; assign ordy[0] = if0.in_ready_o; assign od[0] = if0.out_data_o; assign oocc[0] = if0.occ_o; assign ocnt[0] = if0.stall_cnt_o;
  assign ov[1] = if1.out_valid_o; assign ordy[1] = if1.in_ready_o; assign od[1] = if1.out_data_o; assign oocc[1] = if1.occ_o; assign ocnt[1] = if1.stall_cnt_o;
  assign ov[2] = if2.out_valid_o; assign ordy[2] = if2.in_ready_o; assign od[2] = if2.out_data_o; assign oocc[2] = if2.occ_o; assign ocnt[2] = 16'(if2.stall_cnt_o);

  // Reference: a bounded FIFO (capacity 2 with skid, 1 without) plus a stall counter.
  logic [7:0] fifo [3][2];
  int fsize [3];
  int fstall [3];
  int ncmp = 0;
  int nfail = 0;

  function automatic bit is_skid(input int k);
    return k != 1;
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic bit m_ready(input int k);
    if (!rst) return 1'b1;
    if (is_skid(k)) return fsize[k] < 2;
    return (fsize[k] == 0) || ir[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      fsize[k]   = 0;
      fstall[k]  = 0;
      fifo[k][0] = 8'h00;
      fifo[k][1] = 8'h00;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit acc, drn;
      acc = iv[k] && m_ready(k);
      drn = (fsize[k] > 0) && ir[k];
      if (drn) $display("xfer dut%0d data=%02h", k, fifo[k][0]);
      if ((fsize[k] > 0) && !ir[k] && (fstall[k] < cnt_max(k))) fstall[k]++;
      if (fl[k]) begin
        fsize[k] = 0;
      end else begin
        if (drn) begin
          fifo[k][0] = fifo[k][1];
          fsize[k]--;
        end
        if (acc) begin
          fifo[k][fsize[k]] = id[k];
          fsize[k]++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", k, 32'(ov[k]), 32'(fsize[k] > 0));
      chk("out_data", k, 32'(od[k]), (fsize[k] > 0) ? 32'(fifo[k][0]) : 32'h0);
      chk("occ", k, 32'(oocc[k]), 32'(fsize[k]));
      chk("in_ready", k, 32'(ordy[k]), 32'(m_ready(k)));
      chk("stall_cnt", k, 32'(ocnt[k]), 32'(fstall[k]));
    end
  endtask

  // Inputs are set at the falling edge; check, then let the rising edge act.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ir[k] = 1'b1; fl[k] = 1'b0; id[k] = 8'h00;
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Streaming through the skid stage with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      iv[0] = 1'b1; id[0] = 8'(i);
      tick();
      chk("stream_data", 0, 32'(od[0]), 32'(i));
      chk("stream_rdy", 0, 32'(ordy[0]), 32'h1);
    end
    iv[0] = 1'b0;
    tick();

    // Backpressure: A, B fill the stage, C waits until ready returns.
    ir[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'h0A; tick();
    id[0] = 8'h0B; tick();
    id[0] = 8'h0C;
    #1;
    chk("bp_occ", 0, 32'(oocc[0]), 32'h2);
    chk("bp_rdy", 0, 32'(ordy[0]), 32'h0);
    tick(); tick();
    ir[0] = 1'b1; tick();
    chk("bp_first", 0, 32'(od[0]), 32'h0B);
    tick();
    chk("bp_third", 0, 32'(od[0]), 32'h0C);
    iv[0] = 1'b0; tick(); tick();

    // Flush while full, with a simultaneous offer that must be dropped.
    ir[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'h11; tick();
    id[0] = 8'h22; tick();
    fl[0] = 1'b1; id[0] = 8'h0D; tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("flush_occ", 0, 32'(oocc[0]), 32'h0);
    chk("flush_data", 0, 32'(od[0]), 32'h0);
    ir[0] = 1'b1; tick(); tick();

    // Single-entry stage: blocked when held, same-edge replace when released.
    ir[1] = 1'b0;
    iv[1] = 1'b1; id[1] = 8'h31; tick();
    id[1] = 8'h32;
    #1;
    chk("ns_rdy_blocked", 1, 32'(ordy[1]), 32'h0);
    tick();
    ir[1] = 1'b1; id[1] = 8'h33;
    #1;
    chk("ns_rdy_open", 1, 32'(ordy[1]), 32'h1);
    tick();
    chk("ns_replace", 1, 32'(od[1]), 32'h33);
    chk("ns_occ", 1, 32'(oocc[1]), 32'h1);
    iv[1] = 1'b0; tick(); tick();

    // Counter saturation on the 4-bit variant.
    ir[2] = 1'b0;
    iv[2] = 1'b1; id[2] = 8'h55; tick();
    iv[2] = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 2, 32'(ocnt[2]), 32'hF);
    ir[2] = 1'b1; tick(); tick();

    // Randomised traffic on all three stages.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k] = ($urandom % 4) != 0;
        ir[k] = ($urandom % 3) != 0;
        fl[k] = ($urandom % 32) == 0;
        id[k] = 8'($urandom);
      end
      tick();
    end
    idle_all();

    // Asynchronous reset between edges while the skid stage is full.
    ir[0] = 1'b0; iv[0] = 1'b1;
    id[0] = 8'hE1; tick();
    id[0] = 8'hE2; tick();
    #1;
    chk("pre_rst_occ", 0, 32'(oocc[0]), 32'h2);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_valid", 0, 32'(ov[0]), 32'h0);
    chk("rst_rdy", 0, 32'(ordy[0]), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    idle_all();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
